// File: rtl/coretech_alu.sv
// Registered integer ALU for the CoreTech datapath: 16 ops on A/B,
// result and Zero flag captured on the rising clock edge.
//
// Ports:
//   clk          - system clock, all state updates on rising edge
//   reset        - synchronous active-high reset (ALUResult=0, Zero=1)
//   A, B         - WIDTH-bit operands
//   ALUOperation - 4-bit operation select
//   ALUResult    - registered WIDTH-bit result
//   Zero         - registered flag, 1 when ALUResult is zero
module coretech_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       ALUOperation,
    output logic [WIDTH-1:0] ALUResult,
    output logic             Zero
);

    localparam int SHW  = $clog2(WIDTH);
    localparam int HALF = WIDTH / 2;

    localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

    typedef enum logic [3:0] {
        OP_AND   = 4'd0,
        OP_OR    = 4'd1,
        OP_ADD   = 4'd2,
        OP_XOR   = 4'd3,
        OP_NOR   = 4'd4,
        OP_SLL   = 4'd5,
        OP_SUB   = 4'd6,
        OP_SLT   = 4'd7,
        OP_SLTU  = 4'd8,
        OP_MUL   = 4'd9,
        OP_DIV   = 4'd10,
        OP_REM   = 4'd11,
        OP_SRL   = 4'd12,
        OP_SRA   = 4'd13,
        OP_LUI   = 4'd14,
        OP_PASSA = 4'd15
    } alu_op_e;

    logic [WIDTH-1:0] result_d, result_q;
    logic             zero_d, zero_q;

    logic [SHW-1:0]   sh;
    logic             div_by_zero;
    logic             div_ovf;
    logic [WIDTH-1:0] quot_raw, rem_raw;
    logic [WIDTH-1:0] quot, rem;

    assign sh = B[SHW-1:0];

    assign div_by_zero = (B == '0);
    assign div_ovf     = (A == MIN_NEG) && (B == ALL_ONES);

    // Raw signed divide; its corner cases are overridden below so the
    // result never depends on the simulator's divide-by-zero behaviour.
    always_comb begin
        quot_raw = '0;
        rem_raw  = '0;
        if (!div_by_zero && !div_ovf) begin
            quot_raw = $signed(A) / $signed(B);
            rem_raw  = $signed(A) % $signed(B);
        end
    end

    always_comb begin
        quot = quot_raw;
        rem  = rem_raw;
        if (div_by_zero) begin
            quot = ALL_ONES;
            rem  = A;
        end else if (div_ovf) begin
            quot = MIN_NEG;
            rem  = '0;
        end
    end

    always_comb begin
        result_d = '0;
        case (alu_op_e'(ALUOperation))
            OP_AND:   result_d = A & B;
            OP_OR:    result_d = A | B;
            OP_ADD:   result_d = A + B;
            OP_XOR:   result_d = A ^ B;
            OP_NOR:   result_d = ~(A | B);
            OP_SLL:   result_d = A << sh;
            OP_SUB:   result_d = A - B;
            OP_SLT:   result_d = {{(WIDTH-1){1'b0}},
                                  ($signed(A) < $signed(B))};
            OP_SLTU:  result_d = {{(WIDTH-1){1'b0}}, (A < B)};
            OP_MUL:   result_d = A * B;
            OP_DIV:   result_d = quot;
            OP_REM:   result_d = rem;
            OP_SRL:   result_d = A >> sh;
            OP_SRA:   result_d = $signed(A) >>> sh;
            OP_LUI:   result_d = B << HALF;
            OP_PASSA: result_d = A;
            default:  result_d = '0;
        endcase
    end

    // Zero derives from the same next-state value, so the two outputs
    // are always coherent.
    assign zero_d = (result_d == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            result_q <= '0;
            zero_q   <= 1'b1;
        end else begin
            result_q <= result_d;
            zero_q   <= zero_d;
        end
    end

    assign ALUResult = result_q;
    assign Zero      = zero_q;

endmodule

// File: tb/tb_coretech_alu.sv
// Directed self-checking bench for coretech_alu: one task per feature,
// each with its own vector table and inline comparisons.
module tb_coretech_alu;

    logic        clk;
    logic        reset;
    logic [31:0] A;
    logic [31:0] B;
    logic [3:0]  ALUOperation;
    logic [31:0] ALUResult;
    logic        Zero;

    int n_cmp = 0;
    int n_err = 0;

    coretech_alu #(.WIDTH(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .A            (A),
        .B            (B),
        .ALUOperation (ALUOperation),
        .ALUResult    (ALUResult),
        .Zero         (Zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        A = 32'd21;
        B = 32'd11;
        ALUOperation = 4'd9;
        tick();
        n_cmp++;
        if (ALUResult !== 32'd0 || Zero !== 1'b1) begin
            n_err++;
            $display("FAIL reset_state: got %h/%b want 00000000/1",
                     ALUResult, Zero);
        end
        reset = 1'b0;
        tick();
        n_cmp++;
        if (ALUResult !== 32'd231 || Zero !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release: got %h/%b want %h/0",
                     ALUResult, Zero, 32'd231);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0]  op_t [4] = '{4'd9, 4'd10, 4'd11, 4'd12};
        logic [31:0] r_t  [4] = '{32'd231, 32'd1, 32'd10, 32'd0};
        A = 32'd21;
        B = 32'd11;
        for (int i = 0; i < 4; i++) begin
            ALUOperation = op_t[i];
            tick();
            n_cmp++;
            if (ALUResult !== r_t[i] || Zero !== (r_t[i] == 32'd0)) begin
                n_err++;
                $display("FAIL b2b[%0d] op=%0d: got %h/%b want %h/%b",
                         i, op_t[i], ALUResult, Zero,
                         r_t[i], (r_t[i] == 32'd0));
            end
            // Value must hold for a second edge with a stable op.
            tick();
            n_cmp++;
            if (ALUResult !== r_t[i]) begin
                n_err++;
                $display("FAIL b2b_hold[%0d]: got %h want %h",
                         i, ALUResult, r_t[i]);
            end
        end
    endtask

    task automatic test_between_edges();
        A = 32'h0000_0003;
        B = 32'h0000_0004;
        ALUOperation = 4'd2;
        tick();
        A = 32'hFFFF_0000;
        ALUOperation = 4'd15;
        #3;
        n_cmp++;
        if (ALUResult !== 32'd7 || Zero !== 1'b0) begin
            n_err++;
            $display("FAIL between_edges: got %h/%b want 00000007/0",
                     ALUResult, Zero);
        end
        tick();
        n_cmp++;
        if (ALUResult !== 32'hFFFF_0000) begin
            n_err++;
            $display("FAIL between_edges_next: got %h want ffff0000",
                     ALUResult);
        end
    endtask

    task automatic test_logic_arith();
        logic [3:0]  op_t [6] = '{4'd0, 4'd1, 4'd3, 4'd4, 4'd2, 4'd6};
        logic [31:0] a_t  [6] = '{32'hF0F0F0F0, 32'hF0F0F0F0,
                                  32'hF0F0F0F0, 32'hF0F0F0F0,
                                  32'hFFFFFFFF, 32'd5};
        logic [31:0] b_t  [6] = '{32'h0FF00FF0, 32'h0FF00FF0,
                                  32'h0FF00FF0, 32'h0FF00FF0,
                                  32'd1, 32'd7};
        logic [31:0] r_t  [6] = '{32'h00F000F0, 32'hFFF0FFF0,
                                  32'hFF00FF00, 32'h000F000F,
                                  32'h00000000, 32'hFFFFFFFE};
        for (int i = 0; i < 6; i++) begin
            A = a_t[i];
            B = b_t[i];
            ALUOperation = op_t[i];
            tick();
            n_cmp++;
            if (ALUResult !== r_t[i] || Zero !== (r_t[i] == 32'd0)) begin
                n_err++;
                $display("FAIL logic[%0d] op=%0d: got %h/%b want %h/%b",
                         i, op_t[i], ALUResult, Zero,
                         r_t[i], (r_t[i] == 32'd0));
            end
        end
    endtask

    task automatic test_cmp_shift();
        logic [3:0]  op_t [9] = '{4'd7, 4'd8, 4'd13, 4'd12, 4'd5,
                                  4'd5, 4'd12, 4'd13, 4'd7};
        logic [31:0] a_t  [9] = '{32'hFFFFFFFF, 32'hFFFFFFFF,
                                  32'h80000000, 32'h80000000,
                                  32'd1, 32'd1,
                                  32'h80000001, 32'h80000001,
                                  32'd1};
        logic [31:0] b_t  [9] = '{32'd1, 32'd1, 32'd4, 32'd4,
                                  32'd31, 32'd32, 32'd0, 32'd32,
                                  32'hFFFFFFFF};
        logic [31:0] r_t  [9] = '{32'd1, 32'd0, 32'hF8000000,
                                  32'h08000000, 32'h80000000, 32'd1,
                                  32'h80000001, 32'h80000001, 32'd0};
        for (int i = 0; i < 9; i++) begin
            A = a_t[i];
            B = b_t[i];
            ALUOperation = op_t[i];
            tick();
            n_cmp++;
            if (ALUResult !== r_t[i] || Zero !== (r_t[i] == 32'd0)) begin
                n_err++;
                $display("FAIL cmpshift[%0d] op=%0d: got %h/%b want %h/%b",
                         i, op_t[i], ALUResult, Zero,
                         r_t[i], (r_t[i] == 32'd0));
            end
        end
    endtask

    task automatic test_div_corners();
        logic [3:0]  op_t [6] = '{4'd10, 4'd11, 4'd10, 4'd11,
                                  4'd10, 4'd11};
        logic [31:0] a_t  [6] = '{32'd7, 32'd7,
                                  32'h80000000, 32'h80000000,
                                  32'hFFFFFFF9, 32'hFFFFFFF9};
        logic [31:0] b_t  [6] = '{32'd0, 32'd0,
                                  32'hFFFFFFFF, 32'hFFFFFFFF,
                                  32'd2, 32'd2};
        logic [31:0] r_t  [6] = '{32'hFFFFFFFF, 32'd7,
                                  32'h80000000, 32'd0,
                                  32'hFFFFFFFD, 32'hFFFFFFFF};
        for (int i = 0; i < 6; i++) begin
            A = a_t[i];
            B = b_t[i];
            ALUOperation = op_t[i];
            tick();
            n_cmp++;
            if (ALUResult !== r_t[i] || Zero !== (r_t[i] == 32'd0)) begin
                n_err++;
                $display("FAIL divcorner[%0d] op=%0d: got %h/%b want %h/%b",
                         i, op_t[i], ALUResult, Zero,
                         r_t[i], (r_t[i] == 32'd0));
            end
        end
    endtask

    task automatic test_lui_passa();
        logic [3:0]  op_t [3] = '{4'd14, 4'd15, 4'd15};
        logic [31:0] a_t  [3] = '{32'h55555555, 32'd0, 32'hDEADBEEF};
        logic [31:0] b_t  [3] = '{32'h00001234, 32'h12345678, 32'd0};
        logic [31:0] r_t  [3] = '{32'h12340000, 32'd0, 32'hDEADBEEF};
        for (int i = 0; i < 3; i++) begin
            A = a_t[i];
            B = b_t[i];
            ALUOperation = op_t[i];
            tick();
            n_cmp++;
            if (ALUResult !== r_t[i] || Zero !== (r_t[i] == 32'd0)) begin
                n_err++;
                $display("FAIL luipass[%0d] op=%0d: got %h/%b want %h/%b",
                         i, op_t[i], ALUResult, Zero,
                         r_t[i], (r_t[i] == 32'd0));
            end
        end
    endtask

    task automatic test_midstream_reset();
        A = 32'hDEADBEEF;
        B = 32'd3;
        ALUOperation = 4'd15;
        reset = 1'b1;
        tick();
        n_cmp++;
        if (ALUResult !== 32'd0 || Zero !== 1'b1) begin
            n_err++;
            $display("FAIL mid_reset: got %h/%b want 00000000/1",
                     ALUResult, Zero);
        end
        reset = 1'b0;
        ALUOperation = 4'd6;
        tick();
        n_cmp++;
        if (ALUResult !== 32'hDEADBEEC || Zero !== 1'b0) begin
            n_err++;
            $display("FAIL mid_release: got %h/%b want deadbeec/0",
                     ALUResult, Zero);
        end
    endtask

    initial begin
        reset = 1'b1;
        A = '0;
        B = '0;
        ALUOperation = '0;
        test_reset();
        test_back_to_back();
        test_between_edges();
        test_logic_arith();
        test_cmp_shift();
        test_div_corners();
        test_lui_passa();
        test_midstream_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/coretech_alu.md
Name: coretech_alu

Overview:
- Registered 32-bit integer ALU for the CoreTech processor datapath.
- Sits between the register-file read ports and the writeback/branch logic.
- Each cycle it computes one of 16 operations on A and B, selected by ALUOperation.
- The result and a Zero flag are registered on the rising clock edge.

Parameters:
- WIDTH, 32, datapath width in bits. Must be even and at least 8. All defaults and values below assume 32.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- A  input  WIDTH  operand 1.
- B  input  WIDTH  operand 2.
- ALUOperation  input  4  operation select.
- ALUResult  output  WIDTH  registered result.
- Zero  output  1  registered flag; 1 when ALUResult equals 0.

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high. While reset=1 at a rising edge: ALUResult<=0, Zero<=1. Reset has priority over computation.
- Latency: combinational compute from A, B and ALUOperation sampled at the rising edge. ALUResult and Zero update at that edge, giving 1-cycle latency.
- Throughput: a new operation every cycle. No handshake. Outputs hold between edges.
- Zero is computed from the same next-result value, so it is always consistent with ALUResult in the same cycle.
- Shift amount (sh) = B[4:0], i.e. the low log2(WIDTH) bits. All arithmetic is modulo 2^WIDTH with two's complement and no overflow flag.
- Operation map:
  - 0 AND: A & B
  - 1 OR: A | B
  - 2 ADD: A + B (carry out discarded)
  - 3 XOR: A ^ B
  - 4 NOR: ~(A | B)
  - 5 SLL: A << sh
  - 6 SUB: A - B (borrow discarded)
  - 7 SLT: 1 if signed(A) < signed(B), else 0
  - 8 SLTU: 1 if unsigned(A) < unsigned(B), else 0
  - 9 MUL: low WIDTH bits of A*B (same for signed or unsigned)
  - 10 DIV: signed quotient, truncated toward zero
  - 11 REM: signed remainder; sign follows A
  - 12 SRL: A >> sh, logical (zero fill)
  - 13 SRA: A >>> sh, arithmetic (sign fill)
  - 14 LUI: B << (WIDTH/2)
  - 15 PASSA: A
- Division corner cases:
  - B=0: DIV gives all ones (0xFFFFFFFF); REM gives A.
  - A=0x80000000 and B=0xFFFFFFFF (signed overflow): DIV gives 0x80000000; REM gives 0.
- Shift of 0 returns A unchanged for ops 5, 12 and 13.
- Operand or op changes between edges have no effect on the outputs until the next edge.
- Reset asserted mid-stream: the next edge forces 0/1 regardless of op. The first edge after reset deasserts produces the result of the inputs present at that edge.
- No X propagation from internal state. Outputs are defined from the first reset edge onward.

Test Plan:
- Reset: hold reset=1 for one edge with A=21, B=11, op=9 -> ALUResult=0, Zero=1. Release reset -> the next edge gives 231, Zero=0.
- MUL/DIV/REM/SRL sequence with A=21, B=11:
  - op 9 -> 231
  - op 10 -> 1
  - op 11 -> 10
  - op 12 -> 0 with Zero=1
  - Each value appears one edge after the op is applied and holds while the op is stable.
- Logic/add/sub: A=0xF0F0F0F0, B=0x0FF00FF0:
  - op0 -> 0x00F000F0
  - op1 -> 0xFFF0FFF0
  - op3 -> 0xFF00FF00
  - op4 -> 0x000F000F
  - op2 with A=0xFFFFFFFF, B=1 -> 0, Zero=1
  - op6 with A=5, B=7 -> 0xFFFFFFFE
- Compare and shift: A=0xFFFFFFFF, B=1:
  - op7 -> 1
  - op8 -> 0
  - A=0x80000000, B=4: op13 -> 0xF8000000; op12 -> 0x08000000
  - A=1, B=31: op5 -> 0x80000000
  - A=1, B=32: op5 -> 1 (only low 5 bits of B used)
- Division corners:
  - A=7, B=0: op10 -> 0xFFFFFFFF; op11 -> 7
  - A=0x80000000, B=0xFFFFFFFF: op10 -> 0x80000000; op11 -> 0
  - A=-7, B=2: op10 -> 0xFFFFFFFD; op11 -> 0xFFFFFFFF
- LUI/PASSA:
  - B=0x1234, op14 -> 0x12340000
  - A=0, op15 -> 0 with Zero=1
  - A=0xDEADBEEF, op15 -> 0xDEADBEEF with Zero=0
